pzbcm_ready_slicer: RTL

Multi-stage valid/ready register slice that breaks the backward (ready) timing path, complementing the forward-path slicer in the pzbcm library. Each stage is a two-entry skid buffer whose upstream ready is driven straight from a flop, so no combinational path runs from `i_ready` to `o_ready`. Used on long ready return paths between floorplan partitions without losing throughput.

---
 rtl/pzbcm_ready_slicer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pzbcm_ready_slicer.sv
// Multi-stage valid/ready skid-buffer slice that cuts the backward ready path.
// Define PZBCM_READY_SLICER_ASSERTION_EN to compile in protocol assertions.
module pzbcm_ready_slicer #(
    parameter int  WIDTH     = 1,
    parameter type TYPE      = logic [WIDTH-1:0],
    parameter int  STAGES    = 1,
    parameter bit  USE_RESET = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid,
    output logic o_ready,
    input  TYPE  i_data,
    output logic o_valid,
    input  logic i_ready,
    output TYPE  o_data
);

    logic [STAGES-1:0] main_valid;
    logic [STAGES-1:0] skid_valid;
    logic [STAGES-1:0] ready_q;
    logic [STAGES-1:0] main_valid_d;
    logic [STAGES-1:0] skid_valid_d;
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] dn_ready;
    logic [STAGES-1:0] in_fire;
    logic [STAGES-1:0] out_fire;

    TYPE main_data   [STAGES];
    TYPE skid_data   [STAGES];
    TYPE main_data_d [STAGES];
    TYPE skid_data_d [STAGES];
    TYPE up_data     [STAGES];

    // Neighbour links: every cross-stage signal comes from a flop.
    always_comb begin
        up_valid             = '0;
        dn_ready             = '0;
        up_valid[0]          = i_valid;
        up_data[0]           = i_data;
        dn_ready[STAGES-1]   = i_ready;
        for (int s = 1; s < STAGES; s++) begin
            up_valid[s]   = main_valid[s-1];
            up_data[s]    = main_data[s-1];
            dn_ready[s-1] = ready_q[s];
        end
    end

    always_comb begin
        in_fire      = up_valid & ready_q;
        out_fire     = main_valid & dn_ready;
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        for (int s = 0; s < STAGES; s++) begin
            main_data_d[s] = main_data[s];
            skid_data_d[s] = skid_data[s];
            if (!main_valid[s]) begin
                if (in_fire[s]) begin
                    main_valid_d[s] = 1'b1;
                    main_data_d[s]  = up_data[s];
                end
            end else if (out_fire[s]) begin
                if (skid_valid[s]) begin
                    main_data_d[s]  = skid_data[s];
                    skid_valid_d[s] = 1'b0;
                end else if (in_fire[s]) begin
                    main_data_d[s]  = up_data[s];
                end else begin
                    main_valid_d[s] = 1'b0;
                end
            end else if (in_fire[s]) begin
                skid_valid_d[s] = 1'b1;
                skid_data_d[s]  = up_data[s];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_valid <= '0;
            skid_valid <= '0;
            ready_q    <= '0;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            ready_q    <= ~skid_valid_d;
        end
    end

    if (USE_RESET) begin : g_data_rst
        always_ff @(posedge i_clk) begin
            for (int s = 0; s < STAGES; s++) begin
                if (i_rst) begin
                    main_data[s] <= '0;
                    skid_data[s] <= '0;
                end else begin
                    main_data[s] <= main_data_d[s];
                    skid_data[s] <= skid_data_d[s];
                end
            end
        end
    end else begin : g_data_nrst
        always_ff @(posedge i_clk) begin
            for (int s = 0; s < STAGES; s++) begin
                main_data[s] <= main_data_d[s];
                skid_data[s] <= skid_data_d[s];
            end
        end
    end

    assign o_ready = ready_q[0];
    assign o_valid = main_valid[STAGES-1];
    assign o_data  = main_data[STAGES-1];

`ifdef PZBCM_READY_SLICER_ASSERTION_EN
    a_valid_hold : assert property (
        @(posedge i_clk) disable iff (i_rst)
        i_valid && !o_ready |=> i_valid
    ) else $error("stage 0: i_valid dropped before acceptance");

    a_data_stable : assert property (
        @(posedge i_clk) disable iff (i_rst)
        i_valid && !o_ready |=> $stable(i_data)
    ) else $error("stage 0: i_data changed while stalled");

    for (genvar g = 0; g < STAGES; g++) begin : g_assert
        a_no_skid_ovf : assert property (
            @(posedge i_clk) disable iff (i_rst)
            !(skid_valid[g] && in_fire[g])
        ) else $error("stage %0d: accepted with skid full", g);
    end

    a_valid_known : assert property (
        @(posedge i_clk) !i_rst |-> !$isunknown(o_valid)
    ) else $error("stage %0d: o_valid unknown", STAGES - 1);
`endif

endmodule
